ps2_kbd_ascii: RTL and testbench
================================

# ps2_kbd_ascii

PS/2 keyboard front end for the Apple-1 core: deserializes Set-2 scan codes from the MiST firmware's PS/2 keyboard lines and translates them to 7-bit Apple-1 ASCII. It presents the result as a latched character with a ready flag, matching the PIA keyboard register. It sits between `user_io` (`ps2_kbd_clk`/`ps2_kbd_data`) and the `apple1` PIA, taking PS/2 handling out of the Apple-1 core.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive equal samples required before the filtered PS/2 clock changes.
- `TIMEOUT`, default 14318: clk14 cycles without a falling edge (about 1 ms) before a partial frame is aborted.

Ports:
- `clk14`  in  1  system clock, 14.31818 MHz; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  PS/2 clock from `user_io`; asynchronous.
- `ps2_data`  in  1  PS/2 data from `user_io`; asynchronous.
- `kbd_ack`  in  1  one-cycle pulse when the PIA reads the keyboard register; clears `kbd_ready`.
- `kbd_data`  out  7  latched ASCII character.
- `kbd_ready`  out  1  character available (PIA KBD bit 7).
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.
- `key_reset`  out  1  hotkey reset request (see Configuration).
- `key_cls`  out  1  hotkey clear-screen pulse (see Configuration).

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_data` pass through 2-FF synchronizers. Filtered clock takes a new value only after `FILTER_LEN` consecutive equal synchronized samples. A falling edge of the filtered clock samples synchronized data.
- **Receiver FSM:** states IDLE, DATA, PARITY, STOP.
  - IDLE → DATA on a sampled start bit of 0. A sampled 1 stays in IDLE with no error.
  - DATA shifts 8 bits, LSB first, using a 3-bit counter, then goes to PARITY.
  - PARITY stores the bit.
  - STOP: stop bit = 1 and odd parity over data+parity OK → byte_valid pulse. Otherwise `frame_err` pulse and the byte is discarded. Always returns to IDLE.
  - Timeout counter (14 bits) is cleared on every falling edge and on entering IDLE. If it reaches `TIMEOUT` while not in IDLE: return to IDLE and pulse `frame_err`.
- **Decoder:**
  - `E0` sets the ext flag. `F0` sets the brk flag. The next non-prefix byte consumes both flags.
  - Make/break of 0x12/0x59 updates the shift state. Make/break of 0x14 (with or without ext) updates the ctrl state.
  - Break codes never emit a character. Extended codes emit nothing except `E0 5A` → 0x0D.
- **Mapping (US layout, make codes only):**
  - Letters are always uppercase (0x41–0x5A).
  - Ctrl+letter → letter − 0x40.
  - Digits and punctuation: unshifted/shifted per US layout, folded to 0x20–0x5F; lowercase-range results are forced upper by clearing bit 5.
  - 0x5A → 0x0D, 0x29 → 0x20, 0x66 → 0x5F (Apple-1 rubout), 0x76 → 0x1B.
  - Unmapped codes are ignored.
- **Output latch:**
  - A mapped make code loads `kbd_data` and sets `kbd_ready`.
  - A new key while `kbd_ready`=1 overwrites `kbd_data`.
  - `kbd_ack` with no simultaneous new key clears `kbd_ready`.
  - `kbd_ack` in the same cycle as a new key: the new key wins and `kbd_ready` stays 1.
  - Typematic repeats of a make code emit repeated characters.
- **Reset:** asynchronous. `kbd_data`=0, `kbd_ready`=0, `frame_err`=0, `key_reset`=0, `key_cls`=0. FSM in IDLE; ext, brk, shift and ctrl flags cleared; counters 0; filtered clock = 1.
  - Reset mid-frame discards the partial byte. The first frame after release is received only from a new start bit.

## Timing
- Filter latency is `FILTER_LEN`+2 cycles from a pad edge to the filtered edge.
- `kbd_ready` rises exactly 2 clk14 cycles after the cycle in which the stop bit is sampled: byte_valid at +1, registered decode at +2.
- `frame_err` and `key_cls` are exactly 1 cycle wide.
- `kbd_ready` falls the cycle after `kbd_ack`.
- No back-pressure. Bytes are never dropped by the latch, only overwritten.

## Configuration
- `KBD_HOTKEYS_EN` defined:
  - F12 (0x07) make sets `key_reset`; F12 break clears it. It is a level, held while the key is down.
  - F2 (0x06) make produces a 1-cycle `key_cls` pulse.
  - Neither key emits a character.
- Undefined: `key_reset` and `key_cls` are tied to 0, and 0x07/0x06 are ignored like any unmapped code.

## Test plan
- Frame 0x1C with odd parity 0 at a 12 kHz PS/2 clock → `kbd_data`=0x41, `kbd_ready`=1 two cycles after the stop bit; `kbd_ack` pulse → `kbd_ready`=0 the next cycle.
- Sequence 12, 16, F0 16, F0 12 → exactly one character, 0x21; then a bare 16 → 0x31.
- Frame 0x5A with a wrong parity bit → `frame_err` 1-cycle pulse, `kbd_ready` stays 0. Frame with stop bit 0 → same result.
- Start bit plus 3 data bits, then the clock stops → `frame_err` pulse `TIMEOUT` cycles after the last falling edge; the next good 0x29 → 0x20.
- `E0 5A` → 0x0D. `F0 1C` → no output. Ctrl (14) + 21 → 0x03. Assert `reset` during bit 4 → all outputs 0, next full frame decoded correctly.
- With `KBD_HOTKEYS_EN`: 07 → `key_reset`=1 until F0 07; 06 → a single-cycle `key_cls` pulse, `kbd_ready` unchanged. Without it: both outputs stay 0.

Source files
------------

// File: rtl/ps2_kbd_ascii.sv
// PS/2 Set-2 keyboard to Apple-1 ASCII latch; KBD_HOTKEYS_EN adds F12 reset / F2 clear-screen hotkeys.
// kbd_ready rises 2 cycles after the stop bit is sampled; no back-pressure, a new key overwrites the latch.
module ps2_kbd_ascii #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 14318
) (
   input  logic       clk14,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       kbd_ack,
   output logic [6:0] kbd_data,
   output logic       kbd_ready,
   output logic       frame_err,
   output logic       key_reset,
   output logic       key_cls
);
   localparam int              FW        = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0]   FLT_LAST  = FW'(FILTER_LEN - 1);
   localparam logic [13:0]     TOUT_LAST = 14'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   logic [1:0]    clk_sync, dat_sync;
   logic          clk_filt;
   logic [FW-1:0] flt_cnt;
   logic          fall, din;

   rx_state_t     state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [13:0]   tout_q, tout_d;
   logic          byte_vld, vld_d, err_d;

   logic          ext_q, brk_q, shift_q, ctrl_q;
   logic          prefix, emit;
   logic [7:0]    map_ch;
   logic [6:0]    emit_ch;

   // Synchronizers idle high so reset release never looks like a clock edge.
   always_ff @(posedge clk14 or posedge reset) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_filt <= 1'b1;
         flt_cnt  <= '0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         if (clk_sync[1] != clk_filt) begin
            if (flt_cnt == FLT_LAST) begin
               clk_filt <= clk_sync[1];
               flt_cnt  <= '0;
            end else begin
               flt_cnt <= flt_cnt + 1'b1;
            end
         end else begin
            flt_cnt <= '0;
         end
      end
   end

   assign fall = clk_filt && !clk_sync[1] && (flt_cnt == FLT_LAST);
   assign din  = dat_sync[1];

   always_ff @(posedge clk14 or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         tout_q    <= '0;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         tout_q    <= tout_d;
         byte_vld  <= vld_d;
         frame_err <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      vld_d     = 1'b0;
      err_d     = 1'b0;
      tout_d    = (state_q == IDLE || fall) ? 14'd0 : tout_q + 14'd1;
      if (state_q != IDLE && !fall && tout_q == TOUT_LAST) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end else if (fall) begin
         case (state_q)
            IDLE: begin
               if (!din) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            DATA: begin
               shreg_d   = {din, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = din;
               state_d = STOP;
            end
            default: begin
               if (din && (^{shreg_q, par_q})) vld_d = 1'b1;
               else                             err_d = 1'b1;
               state_d = IDLE;
            end
         endcase
      end
   end

   // US layout; shifted lowercase-range symbols fold down by clearing bit 5.
   function automatic logic [7:0] map_key(input logic [7:0] sc, input logic sh, input logic ct);
      logic [7:0] ch;
      ch = 8'h00;
      case (sc)
         8'h1C: ch = 8'h41;  8'h32: ch = 8'h42;  8'h21: ch = 8'h43;  8'h23: ch = 8'h44;
         8'h24: ch = 8'h45;  8'h2B: ch = 8'h46;  8'h34: ch = 8'h47;  8'h33: ch = 8'h48;
         8'h43: ch = 8'h49;  8'h3B: ch = 8'h4A;  8'h42: ch = 8'h4B;  8'h4B: ch = 8'h4C;
         8'h3A: ch = 8'h4D;  8'h31: ch = 8'h4E;  8'h44: ch = 8'h4F;  8'h4D: ch = 8'h50;
         8'h15: ch = 8'h51;  8'h2D: ch = 8'h52;  8'h1B: ch = 8'h53;  8'h2C: ch = 8'h54;
         8'h3C: ch = 8'h55;  8'h2A: ch = 8'h56;  8'h1D: ch = 8'h57;  8'h22: ch = 8'h58;
         8'h35: ch = 8'h59;  8'h1A: ch = 8'h5A;
         8'h16: ch = sh ? 8'h21 : 8'h31;  8'h1E: ch = sh ? 8'h40 : 8'h32;
         8'h26: ch = sh ? 8'h23 : 8'h33;  8'h25: ch = sh ? 8'h24 : 8'h34;
         8'h2E: ch = sh ? 8'h25 : 8'h35;  8'h36: ch = sh ? 8'h5E : 8'h36;
         8'h3D: ch = sh ? 8'h26 : 8'h37;  8'h3E: ch = sh ? 8'h2A : 8'h38;
         8'h46: ch = sh ? 8'h28 : 8'h39;  8'h45: ch = sh ? 8'h29 : 8'h30;
         8'h4E: ch = sh ? 8'h5F : 8'h2D;  8'h55: ch = sh ? 8'h2B : 8'h3D;
         8'h54: ch = sh ? 8'h7B : 8'h5B;  8'h5B: ch = sh ? 8'h7D : 8'h5D;
         8'h5D: ch = sh ? 8'h7C : 8'h5C;  8'h4C: ch = sh ? 8'h3A : 8'h3B;
         8'h52: ch = sh ? 8'h22 : 8'h27;  8'h41: ch = sh ? 8'h3C : 8'h2C;
         8'h49: ch = sh ? 8'h3E : 8'h2E;  8'h4A: ch = sh ? 8'h3F : 8'h2F;
         8'h0E: ch = sh ? 8'h7E : 8'h60;
         8'h5A: ch = 8'h0D;  8'h29: ch = 8'h20;  8'h66: ch = 8'h5F;  8'h76: ch = 8'h1B;
         default: ch = 8'h00;
      endcase
      if (ct && ch >= 8'h41 && ch <= 8'h5A) ch = ch - 8'h40;
      else if (ch >= 8'h60)                 ch[5] = 1'b0;
      return ch;
   endfunction

   assign prefix  = (shreg_q == 8'hE0) || (shreg_q == 8'hF0);
   assign map_ch  = map_key(shreg_q, shift_q, ctrl_q);
   assign emit    = byte_vld && !prefix && !brk_q &&
                    (ext_q ? (shreg_q == 8'h5A) : (map_ch != 8'h00));
   assign emit_ch = ext_q ? 7'h0D : map_ch[6:0];

   always_ff @(posedge clk14 or posedge reset) begin
      if (reset) begin
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         shift_q   <= 1'b0;
         ctrl_q    <= 1'b0;
         kbd_data  <= '0;
         kbd_ready <= 1'b0;
      end else begin
         if (byte_vld) begin
            if (shreg_q == 8'hE0) begin
               ext_q <= 1'b1;
            end else if (shreg_q == 8'hF0) begin
               brk_q <= 1'b1;
            end else begin
               ext_q <= 1'b0;
               brk_q <= 1'b0;
               if (shreg_q == 8'h12 || shreg_q == 8'h59) shift_q <= !brk_q;
               if (shreg_q == 8'h14)                     ctrl_q  <= !brk_q;
            end
         end
         if (emit) begin
            kbd_data  <= emit_ch;
            kbd_ready <= 1'b1;
         end else if (kbd_ack) begin
            kbd_ready <= 1'b0;
         end
      end
   end

`ifdef KBD_HOTKEYS_EN
   always_ff @(posedge clk14 or posedge reset) begin
      if (reset) begin
         key_reset <= 1'b0;
         key_cls   <= 1'b0;
      end else begin
         key_cls <= 1'b0;
         if (byte_vld && !prefix && !ext_q) begin
            if (shreg_q == 8'h07)           key_reset <= !brk_q;
            if (shreg_q == 8'h06 && !brk_q) key_cls   <= 1'b1;
         end
      end
   end
`else
   assign key_reset = 1'b0;
   assign key_cls   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Directed bench for ps2_kbd_ascii: bit-banged PS/2 frames with hand-computed ASCII results.
module tb_ps2_kbd_ascii;
   localparam int FL = 8;
   localparam int TO = 1500;
   localparam int HS = 597;   // half period of a 12 kHz PS/2 clock in clk14 cycles
   localparam int H  = 20;
`ifdef KBD_HOTKEYS_EN
   localparam logic HK = 1'b1;
`else
   localparam logic HK = 1'b0;
`endif

   logic       clk14 = 1'b0;
   logic       reset, ps2_clk, ps2_data, kbd_ack;
   logic [6:0] kbd_data;
   logic       kbd_ready, frame_err, key_reset, key_cls;

   int tests = 0, fails = 0;
   int err_cnt = 0, err_run = 0, err_max = 0;
   int cls_cnt = 0, cls_run = 0, cls_max = 0;
   int e0, c0, got;

   ps2_kbd_ascii #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk14(clk14), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .kbd_ack(kbd_ack), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
      .frame_err(frame_err), .key_reset(key_reset), .key_cls(key_cls)
   );

   always #35 clk14 = ~clk14;

   always @(negedge clk14) begin
      if (frame_err) begin err_cnt++; err_run++; end else err_run = 0;
      if (err_run > err_max) err_max = err_run;
      if (key_cls) begin cls_cnt++; cls_run++; end else cls_run = 0;
      if (cls_run > cls_max) cls_max = cls_run;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] b, input bit par_ok, input bit stop);
      logic p;
      p = ~^b;
      if (!par_ok) p = ~p;
      return {stop, p, b, 1'b0};
   endfunction

   // Leaves the clock low right after the last falling edge driven.
   task automatic clock_bits(input logic [10:0] bits, input int n, input int half);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (half) @(posedge clk14);
         #1 ps2_clk = 1'b0;
         if (i < n - 1) begin
            repeat (half) @(posedge clk14);
            #1 ps2_clk = 1'b1;
         end
      end
   endtask

   task automatic release_bus(input int half);
      repeat (half) @(posedge clk14);
      #1 ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (half + FL + 8) @(posedge clk14);
      #1;
   endtask

   task automatic send_raw(input logic [7:0] b, input bit par_ok, input bit stop);
      clock_bits(frame(b, par_ok, stop), 11, H);
      release_bus(H);
   endtask

   task automatic send(input logic [7:0] b);
      send_raw(b, 1'b1, 1'b1);
   endtask

   task automatic ack_key();
      @(posedge clk14);
      #1 kbd_ack = 1'b1;
      @(posedge clk14);
      #1 kbd_ack = 1'b0;
      check("ack_clears_ready", kbd_ready, 1'b0);
   endtask

   initial begin
      #(70 * 200000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; kbd_ack = 1'b0;
      repeat (5) @(posedge clk14);
      #1 reset = 1'b0;
      @(posedge clk14); #1;
      check("rst_kbd_data", kbd_data, 7'h00);
      check("rst_kbd_ready", kbd_ready, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_key_reset", key_reset, 1'b0);
      check("rst_key_cls", key_cls, 1'b0);

      // 'A' at 12 kHz with exact ready latency from the stop-bit pad edge
      clock_bits(frame(8'h1C, 1'b1, 1'b1), 11, HS);
      repeat (FL + 2) @(posedge clk14); #1;
      check("a_ready_early", kbd_ready, 1'b0);
      @(posedge clk14); #1;
      check("a_ready_on_time", kbd_ready, 1'b1);
      check("a_data", kbd_data, 7'h41);
      release_bus(HS);
      ack_key();

      // shift handling: exactly one '!' then plain '1'
      send(8'h12);
      check("shift_make_silent", kbd_ready, 1'b0);
      send(8'h16);
      check("shift_1_ready", kbd_ready, 1'b1);
      check("shift_1_data", kbd_data, 7'h21);
      ack_key();
      send(8'hF0); send(8'h16); send(8'hF0); send(8'h12);
      check("breaks_silent", kbd_ready, 1'b0);
      send(8'h16);
      check("plain_1_data", kbd_data, 7'h31);
      ack_key();

      // parity and stop-bit errors
      e0 = err_cnt;
      send_raw(8'h5A, 1'b0, 1'b1);
      check("parity_err_pulses", err_cnt - e0, 1);
      check("parity_err_no_key", kbd_ready, 1'b0);
      e0 = err_cnt;
      send_raw(8'h5A, 1'b1, 1'b0);
      check("stop_err_pulses", err_cnt - e0, 1);
      check("stop_err_no_key", kbd_ready, 1'b0);

      // timeout after start + 3 data bits
      e0 = err_cnt;
      got = 0;
      clock_bits(frame(8'h1C, 1'b1, 1'b1), 4, H);
      for (int k = 1; k <= TO + 100 && got == 0; k++) begin
         @(posedge clk14); #1;
         if (k == H) begin ps2_clk = 1'b1; ps2_data = 1'b1; end
         if (frame_err) got = k;
      end
      check("timeout_latency_in_window", (got >= TO && got <= TO + FL + 6), 1'b1);
      repeat (20) @(posedge clk14); #1;
      check("timeout_single_pulse", err_cnt - e0, 1);
      check("err_pulse_width", err_max, 1);
      send(8'h29);
      check("space_after_timeout", kbd_data, 7'h20);
      ack_key();

      // extended enter, break, ctrl, overwrite
      send(8'hE0); send(8'h5A);
      check("ext_enter", kbd_data, 7'h0D);
      ack_key();
      send(8'hF0); send(8'h1C);
      check("break_no_output", kbd_ready, 1'b0);
      send(8'h14); send(8'h21);
      check("ctrl_c", kbd_data, 7'h03);
      send(8'hF0); send(8'h14);
      send(8'h1C);
      check("overwrite_ready", kbd_ready, 1'b1);
      check("overwrite_data", kbd_data, 7'h41);

      // reset in the middle of a frame
      clock_bits(frame(8'h1C, 1'b1, 1'b1), 5, H);
      @(posedge clk14); #1 reset = 1'b1;
      repeat (3) @(posedge clk14); #1;
      check("midrst_data", kbd_data, 7'h00);
      check("midrst_ready", kbd_ready, 1'b0);
      check("midrst_err", frame_err, 1'b0);
      ps2_clk = 1'b1; ps2_data = 1'b1;
      @(posedge clk14); #1 reset = 1'b0;
      repeat (40) @(posedge clk14); #1;
      send(8'h32);
      check("after_reset_b", kbd_data, 7'h42);
      check("after_reset_ready", kbd_ready, 1'b1);
      ack_key();

      // hotkeys
      send(8'h07);
      check("f12_key_reset", key_reset, HK);
      c0 = cls_cnt;
      send(8'h06);
      check("f2_cls_pulses", cls_cnt - c0, {31'd0, HK});
      check("cls_width", cls_max, {31'd0, HK});
      check("hotkey_no_char", kbd_ready, 1'b0);
      send(8'hF0); send(8'h07);
      check("f12_release", key_reset, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
